// File: rtl/loader_pkg.sv
// Shared constants and state encodings for the UART boot loader.
package loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronized input, mid-bit sampling, one-cycle valid or
// framing-error pulse per byte.
module uart_rx
    import loader_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ferr
);

    localparam int unsigned DIV   = CLK_HZ / BAUD;
    localparam int unsigned CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2 - 1);

    rx_state_e        state_q;
    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             valid_q;
    logic             ferr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (prev_q && !sync2_q) begin
                        state_q <= RX_START;
                        cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    // A line that is high again at mid-start-bit was a glitch.
                    if (cnt_q == HALF) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        if (sync2_q) begin
                            valid_q <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_valid = valid_q;
    assign rx_data  = shift_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: receives a framed, checksummed image over UART, writes it into
// BRAM port A and releases the core reset once the image is verified.
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned MAX_WORDS = 8192
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    logic       rx_valid;
    logic       rx_ferr;
    logic [7:0] rx_data;

    uart_rx #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .uart_rx (uart_rx),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .rx_ferr (rx_ferr)
    );

    ld_state_e         state_q;
    logic [15:0]       len_q;
    logic [7:0]        csum_q;
    logic [1:0]        byte_idx_q;
    logic [3:0]        mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_din_q;
    logic              core_rst_n_q;
    logic              done_q;
    logic              err_q;

    logic [15:0] len_d;
    logic [7:0]  csum_d;
    logic        word_last;
    logic        len_bad;
    logic        ferr_abort;

    assign len_d      = {rx_data, len_q[7:0]};
    assign csum_d     = csum_q + rx_data;
    assign word_last  = (32'(mem_addr_q) == (32'(len_q) - 32'd1));
    assign len_bad    = (len_d == 16'd0) || (32'(len_d) > MAX_WORDS);
    assign ferr_abort = rx_ferr && (state_q != ST_IDLE) && (state_q != ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            csum_q       <= '0;
            byte_idx_q   <= '0;
            mem_we_q     <= '0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            mem_we_q <= '0;
            // Address advances the cycle after a write so it stays stable
            // during the strobe; the last word leaves DATA and keeps N-1.
            if (mem_we_q != '0 && state_q == ST_DATA) begin
                mem_addr_q <= mem_addr_q + 1'b1;
            end
            if (ferr_abort) begin
                state_q <= ST_ERR;
                err_q   <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_valid && rx_data == SYNC_BYTE) begin
                            state_q    <= ST_LEN0;
                            err_q      <= 1'b0;
                            csum_q     <= '0;
                            mem_addr_q <= '0;
                            byte_idx_q <= '0;
                        end
                    end
                    ST_LEN0: begin
                        if (rx_valid) begin
                            len_q[7:0] <= rx_data;
                            state_q    <= ST_LEN1;
                        end
                    end
                    ST_LEN1: begin
                        if (rx_valid) begin
                            len_q <= len_d;
                            if (len_bad) begin
                                state_q <= ST_ERR;
                                err_q   <= 1'b1;
                            end else begin
                                state_q <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (rx_valid) begin
                            mem_din_q[{byte_idx_q, 3'b000} +: 8] <= rx_data;
                            csum_q     <= csum_d;
                            byte_idx_q <= byte_idx_q + 1'b1;
                            if (byte_idx_q == 2'd3) begin
                                mem_we_q <= 4'hF;
                                if (word_last) begin
                                    state_q <= ST_CSUM;
                                end
                            end
                        end
                    end
                    ST_CSUM: begin
                        if (rx_valid) begin
                            if (rx_data == csum_q) begin
                                state_q      <= ST_DONE;
                                done_q       <= 1'b1;
                                core_rst_n_q <= 1'b1;
                            end else begin
                                state_q <= ST_ERR;
                                err_q   <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: state_q <= ST_DONE;
                    ST_ERR:  state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign core_rst_n = core_rst_n_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                        (state_q == ST_DATA) || (state_q == ST_CSUM);

endmodule

// File: tb/tb_uart_imem_loader.sv
// Scoreboard bench for uart_imem_loader: expected BRAM writes are queued by the
// stimulus and popped by an independent write monitor.
module tb_uart_imem_loader;

    typedef struct packed {
        logic [12:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        uart_rx;
    logic [3:0]  mem_we;
    logic [12:0] mem_addr;
    logic [31:0] mem_din;
    logic        core_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    int nchecks = 0;
    int nerrors = 0;
    wr_t exp_q[$];
    logic prev_we = 1'b0;

    uart_imem_loader #(
        .CLK_HZ   (16),
        .BAUD     (1),
        .ADDR_W   (13),
        .MAX_WORDS(8192)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .core_rst_n(core_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Write monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        wr_t e;
        if (mem_we !== 4'h0) begin
            nchecks++;
            if (prev_we) begin
                nerrors++;
                $display("FAIL we_spacing: mem_we high in consecutive cycles (we=%h)", mem_we);
            end
            if (exp_q.size() == 0) begin
                nerrors++;
                $display("FAIL unexpected_write: we=%h addr=%h din=%h, no write required",
                         mem_we, mem_addr, mem_din);
            end else begin
                e = exp_q.pop_front();
                if (mem_we !== 4'hF || mem_addr !== e.addr || mem_din !== e.data) begin
                    nerrors++;
                    $display("FAIL write: got we=%h addr=%h din=%h, required we=f addr=%h din=%h",
                             mem_we, mem_addr, mem_din, e.addr, e.data);
                end
            end
        end
        prev_we = (mem_we !== 4'h0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_drained(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (16) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (16) @(posedge clk);
        end
        uart_rx = stop;
        repeat (16) @(posedge clk);
        uart_rx = 1'b1;
        repeat (16) @(posedge clk);
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send_byte(s[i], 1'b1);
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({name, "_we"},      32'(mem_we),     32'd0);
        check({name, "_addr"},    32'(mem_addr),   32'd0);
        check({name, "_din"},     mem_din,         32'd0);
        check({name, "_core"},    32'(core_rst_n), 32'd0);
        check({name, "_busy"},    32'(busy),       32'd0);
        check({name, "_done"},    32'(done),       32'd0);
        check({name, "_err"},     32'(err),        32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic check_status(input string name, input logic e_done, input logic e_core,
                                input logic e_busy, input logic e_err);
        @(negedge clk);
        check({name, "_done"}, 32'(done),       32'(e_done));
        check({name, "_core"}, 32'(core_rst_n), 32'(e_core));
        check({name, "_busy"}, 32'(busy),       32'(e_busy));
        check({name, "_err"},  32'(err),        32'(e_err));
    endtask

    initial begin
        logic [7:0] f[$];
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        repeat (2) @(posedge clk);
        do_reset("rst0");

        // Two-word frame with a bad checksum: words land, then rejection.
        exp_q.push_back('{13'd0, 32'h00000013});
        exp_q.push_back('{13'd1, 32'h00100093});
        f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, 8'hB7};
        send_seq(f);
        check_status("badcsum", 1'b0, 1'b0, 1'b0, 1'b1);
        check_drained("badcsum_writes");

        // Same frame, correct checksum; sync must clear err immediately.
        exp_q.push_back('{13'd0, 32'h00000013});
        exp_q.push_back('{13'd1, 32'h00100093});
        send_byte(8'hA5, 1'b1);
        check_status("sync", 1'b0, 1'b0, 1'b1, 1'b0);
        f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        send_seq(f);
        check_status("good", 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("good_last_addr", 32'(mem_addr), 32'd1);
        check_drained("good_writes");

        // DONE ignores everything, including a new sync byte.
        f = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        send_seq(f);
        check_status("done_sticky", 1'b1, 1'b1, 1'b0, 1'b0);
        check_drained("done_nowrite");

        do_reset("rst1");

        // Leading garbage before the sync byte.
        exp_q.push_back('{13'd0, 32'hDEADBEEF});
        f = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00,
              8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
        send_seq(f);
        check_status("garbage", 1'b1, 1'b1, 1'b0, 1'b0);
        check_drained("garbage_writes");

        do_reset("rst2");

        // Length bounds: zero and MAX_WORDS+1 are both rejected without writes.
        f = '{8'hA5, 8'h00, 8'h00};
        send_seq(f);
        check_status("len0", 1'b0, 1'b0, 1'b0, 1'b1);
        f = '{8'hA5, 8'h01, 8'h20};
        send_seq(f);
        check_status("len2001", 1'b0, 1'b0, 1'b0, 1'b1);
        check_drained("len_nowrite");

        do_reset("rst3");

        // Framing error on the second payload byte.
        f = '{8'hA5, 8'h01, 8'h00, 8'h11};
        send_seq(f);
        send_byte(8'h22, 1'b0);
        check_status("ferr", 1'b0, 1'b0, 1'b0, 1'b1);
        f = '{8'h33, 8'h44};
        send_seq(f);
        check_status("ferr_idle", 1'b0, 1'b0, 1'b0, 1'b1);
        check_drained("ferr_nowrite");

        do_reset("rst4");

        // Reset in the middle of a word, then a fresh frame.
        f = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
        send_seq(f);
        check_status("midframe", 1'b0, 1'b0, 1'b1, 1'b0);
        do_reset("rst_mid");
        exp_q.push_back('{13'd0, 32'h12345678});
        f = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
        send_seq(f);
        check_status("reload", 1'b1, 1'b1, 1'b0, 1'b0);
        check_drained("reload_writes");

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
